if_prefetch_stage: RTL and testbench
====================================

Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage for the RISC-V pipeline. It replaces the single-register PC fetch with a decoupled fetch engine. It issues sequential requests to a synchronous instruction memory with 1-cycle read latency and buffers returned instructions with their PCs in a prefetch FIFO. It hands them to ID over a valid/ready handshake, and supports branch redirect with flush of queued and in-flight fetches.

Parameters:
XLEN, 32, width of PC, address and instruction
FIFO_DEPTH, 4, prefetch queue entries; power of 2, >= 2
RESET_PC, 0, fetch PC loaded on reset

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
PCSrc  input  1  redirect request from EX; takes effect at the next clk edge
PC_Branch  input  XLEN  redirect target; bits [1:0] ignored (forced 0)
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  XLEN  byte address of request (word aligned)
imem_rdata  input  XLEN  read data, valid exactly 1 cycle after imem_req
IF_valid  output  1  PC_IF/INSTRUCTION_IF hold a valid fetched instruction
IF_ready  input  1  ID accepts the head instruction
PC_IF  output  XLEN  PC of head instruction; 0 when IF_valid=0
INSTRUCTION_IF  output  XLEN  head instruction; 0 when IF_valid=0

Behaviour:
- Reset (priority over everything): fetch_pc<=RESET_PC, FIFO emptied, in-flight flag cleared. While reset=1: imem_req=0, IF_valid=0, PC_IF=0, INSTRUCTION_IF=0.
- Issue rule, combinational: imem_req = !reset && !PCSrc && (count + inflight < FIFO_DEPTH).
  - count = FIFO occupancy; inflight = request issued last cycle.
  - A pop in the same cycle does not free a credit until the next cycle.
- imem_addr = fetch_pc. On issue: fetch_pc <= fetch_pc + 4, modulo 2^XLEN (wraps to 0). The request's PC is recorded as inflight_pc.
- Response: in the cycle after an issue, {inflight_pc, imem_rdata} is pushed at the clock edge unless squashed. Overflow is impossible by the credit rule.
- Output: head of FIFO. Pop when IF_valid && IF_ready. Push and pop may occur in the same cycle.
- Latency: request in cycle 0 → IF_valid in cycle 2. Steady-state throughput is 1 instruction/cycle with IF_ready held high.
- Redirect, PCSrc=1 in cycle N:
  - At edge N: FIFO cleared, the response arriving in cycle N is discarded, and fetch_pc <= {PC_Branch[XLEN-1:2],2'b00}.
  - imem_req=0 in cycle N. First new request in cycle N+1. IF_valid=1 in N+3 with PC_IF = target.
  - A handshake in cycle N counts as squashed; ID must ignore it.
  - Back-to-back PCSrc: last one wins.
- Reset mid-operation: same as reset above, with a clean restart at RESET_PC the cycle after reset falls.
- FIFO full with IF_ready=0: imem_req=0 and outputs hold stable.
- FIFO empty: IF_valid=0 and outputs are 0.

Optional Feature:
IF_FETCH_BYPASS_EN
- Defined: when the FIFO is empty, an arriving non-squashed response drives the outputs directly in its arrival cycle, with IF_valid=1.
  - If IF_ready=1, it is consumed with no FIFO write; otherwise it is written to the FIFO.
  - Latency becomes request cycle 0 → IF_valid in cycle 1; redirect → IF_valid in N+2.
- Undefined: all responses pass through the FIFO, with the latencies stated in Behaviour.

Test Plan:
Memory model returns imem_rdata = addr ^ 32'hA5A5_0000 for the request made the previous cycle.
- Reset 2 cycles, then IF_ready=1 → imem_req=1 with imem_addr=0 in cycle 0. IF_valid=1 in cycle 2 with PC_IF=0, INSTRUCTION_IF=0xA5A50000. Then PC_IF=4, 8, 12… every cycle with no bubbles.
- IF_ready=0 after reset → imem_req drops after 4 issues (count+inflight=4). PC_IF stays 0. Raise IF_ready → PC_IF 0, 4, 8, 12, 16, 20 on consecutive cycles.
- FIFO full (PCs 0–12) and PCSrc=1, PC_Branch=0x100 in cycle N → IF_valid=0 in N+1 and N+2. In N+3, PC_IF=0x100 and INSTRUCTION_IF=0xA5A50100. No stale PC 0–16 appears afterwards.
- PC_Branch=0x102 → imem_addr=0x100 in N+1. Also PCSrc in N and N+1 with targets 0x200 and 0x300 → first IF_valid has PC_IF=0x300.
- RESET_PC=32'hFFFF_FFF8, free run → PC_IF sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- Reset asserted for 1 cycle mid-stream with FIFO half full → IF_valid=0 next cycle. Restart from RESET_PC with the cycle-2 latency. With IF_FETCH_BYPASS_EN, the first test gives IF_valid in cycle 1 with PC_IF=0.

Source files
------------

// File: rtl/if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// if_prefetch_stage
//
// Decoupled instruction-fetch stage. Sequential word requests go to a
// synchronous instruction memory with a one-cycle read latency. Each
// response is buffered together with its PC in a small prefetch FIFO. The
// head of the FIFO is presented to ID over a valid/ready handshake. A branch
// redirect from EX flushes both the queued entries and the in-flight fetch.
//
// Parameters:
//   XLEN        width of PC, address and instruction
//   FIFO_DEPTH  prefetch queue entries (power of 2, >= 2)
//   RESET_PC    fetch PC loaded on reset
//
// Ports:
//   clk             clock
//   reset           synchronous, active-high reset
//   PCSrc           redirect request from EX, applied at the next clk edge
//   PC_Branch       redirect target (bits [1:0] are ignored)
//   imem_req        read request to instruction memory this cycle
//   imem_addr       word-aligned byte address of the request
//   imem_rdata      read data, valid one cycle after imem_req
//   IF_valid        PC_IF / INSTRUCTION_IF hold a fetched instruction
//   IF_ready        ID accepts the head instruction
//   PC_IF           PC of the head instruction (0 when IF_valid = 0)
//   INSTRUCTION_IF  head instruction (0 when IF_valid = 0)
//
// Build option:
//   IF_FETCH_BYPASS_EN  when defined, a response that arrives while the FIFO
//                       is empty drives the outputs in its arrival cycle,
//                       saving one cycle of fetch latency.
// ---------------------------------------------------------------------------
module if_prefetch_stage #(
    parameter int              XLEN       = 32,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PC_Branch,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            IF_valid,
    input  logic            IF_ready,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] INSTRUCTION_IF
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
    logic [XLEN-1:0] instr_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            inflight;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] fetch_pc;

    logic [CW-1:0]   credit_used;
    logic            issue;
    logic            rsp_ok;
    logic            fifo_nonempty;
    logic            bypass_hit;
    logic            head_valid;
    logic            push;
    logic            pop;

    // The low target bits are architecturally ignored.
    logic [1:0]      unused_branch_bits;
    assign unused_branch_bits = PC_Branch[1:0];

    // Credit-based issue: a request is only sent when the FIFO is guaranteed
    // to have room for its response, counting the one still in flight. A pop
    // this cycle is not visible in count until next cycle, so the FIFO can
    // never overflow.
    always_comb begin
        credit_used   = count + CW'(inflight);
        issue         = !reset && !PCSrc && (credit_used < CW'(FIFO_DEPTH));
        rsp_ok        = !reset && inflight && !PCSrc;
        fifo_nonempty = (count != '0);
`ifdef IF_FETCH_BYPASS_EN
        bypass_hit    = rsp_ok && !fifo_nonempty;
`else
        bypass_hit    = 1'b0;
`endif
        head_valid    = fifo_nonempty || bypass_hit;
        pop           = !reset && fifo_nonempty && IF_ready;
        push          = rsp_ok && !(bypass_hit && IF_ready);
    end

    // Output mux: FIFO head when occupied, otherwise the bypassed response.
    // Everything is forced to zero whenever nothing valid is presented.
    always_comb begin
        imem_req       = issue;
        imem_addr      = fetch_pc;
        IF_valid       = !reset && head_valid;
        PC_IF          = '0;
        INSTRUCTION_IF = '0;
        if (IF_valid) begin
            if (fifo_nonempty) begin
                PC_IF          = pc_mem[rd_ptr];
                INSTRUCTION_IF = instr_mem[rd_ptr];
            end else begin
                PC_IF          = inflight_pc;
                INSTRUCTION_IF = imem_rdata;
            end
        end
    end

    // Control state: fetch PC, in-flight tracking and FIFO pointers. A
    // redirect empties the queue and, because rsp_ok is low, also drops the
    // response arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (PCSrc) begin
                fetch_pc <= {PC_Branch[XLEN-1:2], 2'b00};
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // FIFO storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// ---------------------------------------------------------------------------
// tb_if_prefetch_stage
//
// Directed bench for if_prefetch_stage. Two instances share the stimulus:
// one with RESET_PC = 0 and one with RESET_PC = 0xFFFF_FFF8 to observe PC
// wrap-around. Each has its own memory model returning addr ^ 0xA5A5_0000
// one cycle after the request. Inputs change 1 time unit after the rising
// edge and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_if_prefetch_stage;

`ifdef IF_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] PC_Branch;
    logic        IF_ready;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        IF_valid;
    logic [31:0] PC_IF;
    logic [31:0] INSTRUCTION_IF;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] imem_rdata_w;
    logic        IF_valid_w;
    logic [31:0] PC_IF_w;
    logic [31:0] INSTRUCTION_IF_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if_prefetch_stage #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .IF_valid       (IF_valid),
        .IF_ready       (IF_ready),
        .PC_IF          (PC_IF),
        .INSTRUCTION_IF (INSTRUCTION_IF)
    );

    if_prefetch_stage #(.XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk            (clk),
        .reset          (reset),
        .PCSrc          (PCSrc),
        .PC_Branch      (PC_Branch),
        .imem_req       (imem_req_w),
        .imem_addr      (imem_addr_w),
        .imem_rdata     (imem_rdata_w),
        .IF_valid       (IF_valid_w),
        .IF_ready       (IF_ready),
        .PC_IF          (PC_IF_w),
        .INSTRUCTION_IF (INSTRUCTION_IF_w)
    );

    // Synchronous memory models with one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= imem_addr ^ MAGIC;
        if (imem_req_w) imem_rdata_w <= imem_addr_w ^ MAGIC;
    end

    // Drive one cycle of inputs, then wait for the sampling point.
    task automatic applyStimulus(input logic r, input logic p,
                                 input logic [31:0] br, input logic rdy);
        @(posedge clk);
        #1;
        reset     = r;
        PCSrc     = p;
        PC_Branch = br;
        IF_ready  = rdy;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        PCSrc     = 1'b0;
        PC_Branch = '0;
        IF_ready  = 1'b0;

        // ---- Reset state and streaming fetch ---------------------------
        $display("[TB] streaming after reset");
        applyStimulus(1, 0, 0, 1);
        applyStimulus(1, 0, 0, 1);
        checkOutput("rst_req",   32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(IF_valid), 32'd0);
        checkOutput("rst_pc",    PC_IF, 32'd0);
        checkOutput("rst_instr", INSTRUCTION_IF, 32'd0);
        checkOutput("rst_valid_w", 32'(IF_valid_w), 32'd0);
        for (int c = 0; c < 8; c++) begin
            applyStimulus(0, 0, 0, 1);
            if (c == 0) begin
                checkOutput("s_req0",  32'(imem_req), 32'd1);
                checkOutput("s_addr0", imem_addr, 32'd0);
            end
            if (c < LAT) begin
                checkOutput("s_lat_valid", 32'(IF_valid), 32'd0);
            end else begin
                checkOutput("s_valid", 32'(IF_valid), 32'd1);
                checkOutput("s_pc",    PC_IF, 32'(4 * (c - LAT)));
                checkOutput("s_instr", INSTRUCTION_IF, 32'(4 * (c - LAT)) ^ MAGIC);
                if (c - LAT < 4) begin
                    checkOutput("wrap_pc", PC_IF_w, 32'hFFFF_FFF8 + 32'(4 * (c - LAT)));
                    checkOutput("wrap_instr", INSTRUCTION_IF_w,
                                (32'hFFFF_FFF8 + 32'(4 * (c - LAT))) ^ MAGIC);
                end
            end
        end

        // ---- Back-pressure: credit limit and drain ----------------------
        $display("[TB] back-pressure");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 0, 0);
            checkOutput("bp_req", 32'(imem_req), (c < 4) ? 32'd1 : 32'd0);
            if (c >= 4) begin
                checkOutput("bp_hold_valid", 32'(IF_valid), 32'd1);
                checkOutput("bp_hold_pc", PC_IF, 32'd0);
            end
        end
        for (int c = 0; c < 6; c++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("drain_valid", 32'(IF_valid), 32'd1);
            checkOutput("drain_pc", PC_IF, 32'(4 * c));
        end

        // ---- Redirect with a full FIFO ----------------------------------
        $display("[TB] redirect with full FIFO");
        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        for (int c = 0; c < 6; c++) applyStimulus(0, 0, 0, 0);
        checkOutput("full_req", 32'(imem_req), 32'd0);
        applyStimulus(0, 1, 32'h100, 0);
        checkOutput("redir_req", 32'(imem_req), 32'd0);
        for (int k = 1; k <= LAT + 3; k++) begin
            applyStimulus(0, 0, 0, 1);
            if (k == 1) begin
                checkOutput("redir_req1",  32'(imem_req), 32'd1);
                checkOutput("redir_addr1", imem_addr, 32'h100);
            end
            if (k < LAT + 1) begin
                checkOutput("redir_bubble", 32'(IF_valid), 32'd0);
            end else begin
                checkOutput("redir_valid", 32'(IF_valid), 32'd1);
                checkOutput("redir_pc", PC_IF, 32'h100 + 32'(4 * (k - LAT - 1)));
                checkOutput("redir_instr", INSTRUCTION_IF,
                            (32'h100 + 32'(4 * (k - LAT - 1))) ^ MAGIC);
            end
        end

        // ---- Misaligned target and back-to-back redirects ---------------
        $display("[TB] misaligned and back-to-back redirects");
        applyStimulus(0, 1, 32'h102, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("align_addr", imem_addr, 32'h100);
        checkOutput("align_req",  32'(imem_req), 32'd1);
        applyStimulus(0, 1, 32'h200, 1);
        applyStimulus(0, 1, 32'h300, 1);
        checkOutput("b2b_req", 32'(imem_req), 32'd0);
        for (int k = 1; k <= LAT + 1; k++) begin
            applyStimulus(0, 0, 0, 1);
            if (k == 1) checkOutput("b2b_addr", imem_addr, 32'h300);
            if (k <= LAT) begin
                checkOutput("b2b_bubble", 32'(IF_valid), 32'd0);
            end else begin
                checkOutput("b2b_valid", 32'(IF_valid), 32'd1);
                checkOutput("b2b_pc", PC_IF, 32'h300);
            end
        end

        // ---- Reset mid-stream with a half-full FIFO ---------------------
        $display("[TB] reset mid-stream");
        applyStimulus(1, 0, 0, 0);
        for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        checkOutput("mid_rst_valid", 32'(IF_valid), 32'd0);
        checkOutput("mid_rst_req",   32'(imem_req), 32'd0);
        for (int c = 0; c <= LAT; c++) begin
            applyStimulus(0, 0, 0, 1);
            if (c == 0) begin
                checkOutput("restart_req",  32'(imem_req), 32'd1);
                checkOutput("restart_addr", imem_addr, 32'd0);
            end
            if (c < LAT) begin
                checkOutput("restart_bubble", 32'(IF_valid), 32'd0);
            end else begin
                checkOutput("restart_valid", 32'(IF_valid), 32'd1);
                checkOutput("restart_pc", PC_IF, 32'd0);
                checkOutput("restart_pc_w", PC_IF_w, 32'hFFFF_FFF8);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
